apb_uart_regif: RTL and testbench
=================================

Name: apb_uart_regif

Overview:
- APB3 responder (completer) exposing the UART to a CPU bus initiator.
- Drives tx_data, tx_start and cfg_reg into the existing uart_tx.
- Buffers received bytes from the existing uart_rx in a small RX FIFO.
- Reports status flags and sticky errors; sits between the APB interconnect and the TX/RX cores.

Parameters:
- ADDR_W, 4, APB address width; only paddr[3:2] is decoded.
- RX_DEPTH, 4, RX FIFO depth in entries; must be a power of 2, at least 2.
- CFG_RESET, 5'b00011, reset value of cfg_reg (8N1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle start pulse to the TX core
- cfg_reg  out  5  [1:0] data bits minus 5, [2] two stop bits, [3] parity enable, [4] odd parity
- tx_busy  in  1  TX core busy
- tx_done  in  1  TX core completion pulse
- rx_data  in  8  received byte
- rx_done  in  1  RX core completion pulse
- parity_error  in  1  RX parity error; valid when rx_done is high

Behaviour:
- Reset values:
  - prdata=0, pslverr=0, tx_data=0, tx_start=0, cfg_reg=CFG_RESET.
  - FIFO empty; all sticky flags 0.
- pready is tied to 1: zero wait states. A transfer completes in the cycle where psel & penable are both high.
- prdata:
  - Registered during the setup phase (psel & !penable & !pwrite); held during access; 0 otherwise.
  - The DATA register loads the FIFO head, not live RX data.
- pslverr is combinational, asserted only during a completing access.
- Register map:
  - 0x0 DATA
    - Write: if !tx_busy_eff, latch pwdata[7:0] into tx_data and pulse tx_start for exactly 1 cycle (next clk).
    - If tx_busy_eff: pslverr=1, byte dropped, no pulse.
    - Read: returns {23'b0, perr, byte} from the FIFO head, then pops at access completion. Empty FIFO returns 0, no pop, pslverr=0.
  - 0x4 CFG
    - R/W bits [4:0]; the other bits read 0.
    - A write while tx_busy_eff gets pslverr=1 and is ignored.
  - 0x8 STATUS (RO except W1C bits)
    - [0] tx_busy_eff
    - [1] rx_not_empty
    - [2] rx_full
    - [3] perr_sticky (W1C)
    - [4] overrun_sticky (W1C)
    - [5] tx_done_sticky (W1C)
  - 0xC IRQ_EN: see Optional Feature; reads 0 when the feature is compiled out.
- tx_busy_eff = tx_busy | tx_start | start_q, where start_q is tx_start delayed by 1 cycle. This covers the gap before the TX core raises busy.
- RX FIFO:
  - 9-bit entries {parity_error, rx_data}.
  - Binary read/write pointers of width log2(RX_DEPTH)+1; full/empty via MSB compare; pointers wrap naturally.
  - Push on rx_done when not full. rx_done while full: drop the byte and set overrun_sticky.
  - Push and pop in the same cycle: both occur. When full, the push is accepted with no overrun.
  - perr_sticky is set on any push whose parity_error = 1.
- Sticky-flag priority: a set event in the same cycle as a W1C clear wins (flag stays 1).
- tx_done_sticky is set on a tx_done pulse.
- Reset mid-transfer aborts any APB transfer. The FIFO is flushed and tx_start deasserts immediately (asynchronous).

Optional Feature:
- Macro: APB_UART_REGIF_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and R/W register IRQ_EN at 0xC, bits [2:0] = {tx_done, overrun, rx_not_empty}, reset 0.
  - irq is registered and equals |(IRQ_EN & {tx_done_sticky, overrun_sticky, rx_not_empty}).
- When undefined: no irq port; 0xC reads 0 and writes are ignored without error.

Decomposition:
- Package apb_uart_pkg holds:
  - address offsets DATA_OFS, CFG_OFS, STATUS_OFS, IRQEN_OFS;
  - STATUS bit indices;
  - a packed struct for the 5-bit cfg fields;
  - localparam CFG_8N1.
- One sub-module, apb_uart_rx_fifo: parameterised synchronous FIFO with push, pop, full, empty and dout.

Test Plan:
- Reset, then read CFG and STATUS: expect 0x03 and 0x00; pslverr=0.
- Write DATA 0x55 with tx_busy held low: tx_start pulses 1 cycle and tx_data=0x55. A second DATA write 1 cycle later gets pslverr=1 and no pulse.
- Pulse rx_done with rx_data=0xA5, parity_error=0: STATUS[1]=1. DATA read returns 0x0A5, then STATUS[1]=0. Reading DATA again returns 0.
- Push 5 bytes 0x01..0x05 with RX_DEPTH=4: overrun_sticky=1. Reads return 0x01..0x04. Writing STATUS 0x10 clears overrun.
- rx_done with parity_error=1 and data 0x3C: DATA read returns 0x13C and STATUS[3]=1. A W1C in the same cycle as a new errored push leaves bit 3 set.
- With APB_UART_REGIF_IRQ_EN defined: IRQ_EN=0x1, push one byte → irq=1 on the following cycle; pop it → irq=0.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - register offsets, STATUS bit indices and cfg layout for apb_uart_regif
package apb_uart_pkg;

    localparam logic [1:0] DATA_OFS   = 2'd0;
    localparam logic [1:0] CFG_OFS    = 2'd1;
    localparam logic [1:0] STATUS_OFS = 2'd2;
    localparam logic [1:0] IRQEN_OFS  = 2'd3;

    localparam int unsigned ST_TX_BUSY  = 0;
    localparam int unsigned ST_RX_AVAIL = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_PERR     = 3;
    localparam int unsigned ST_OVERRUN  = 4;
    localparam int unsigned ST_TX_DONE  = 5;

    typedef struct packed {
        logic       odd_parity;
        logic       parity_en;
        logic       two_stop;
        logic [1:0] data_bits_m5;
    } cfg_t;

    localparam logic [4:0] CFG_8N1 = 5'b00011;

endpackage

// File: rtl/apb_uart_rx_fifo.sv
// rtl/apb_uart_rx_fifo.sv - synchronous FIFO with binary wrap pointers for received UART bytes
module apb_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/apb_uart_regif.sv
// rtl/apb_uart_regif.sv - APB3 register interface for the UART TX/RX cores; optional irq via APB_UART_REGIF_IRQ_EN
module apb_uart_regif
    import apb_uart_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter int         RX_DEPTH  = 4,
    parameter logic [4:0] CFG_RESET = CFG_8N1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [4:0]        cfg_reg,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              parity_error
`ifdef APB_UART_REGIF_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic       setup;
    logic       access;
    logic [1:0] reg_sel;
    logic       start_q;
    logic       tx_busy_eff;
    logic       wr_data;
    logic       wr_cfg;
    logic       wr_status;
    logic       tx_accept;
    logic       pop_armed;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [8:0] fifo_dout;
    logic       overrun_set;
    logic       perr_set;
    logic       perr_sticky;
    logic       overrun_sticky;
    logic       tx_done_sticky;
    logic [5:0] status_vec;
    logic [31:0] rdata;
    cfg_t       cfg_q;
    logic       unused_bits;

    assign pready      = 1'b1;
    assign setup       = psel & ~penable;
    assign access      = psel & penable;
    assign reg_sel     = paddr[3:2];
    assign cfg_reg     = cfg_q;
    assign unused_bits = ^{pwdata[31:8], paddr};

    // The TX core raises busy a cycle or two after the start pulse; cover that gap.
    assign tx_busy_eff = tx_busy | tx_start | start_q;

    assign wr_data   = access & pwrite & (reg_sel == DATA_OFS);
    assign wr_cfg    = access & pwrite & (reg_sel == CFG_OFS);
    assign wr_status = access & pwrite & (reg_sel == STATUS_OFS);
    assign tx_accept = wr_data & ~tx_busy_eff;
    assign pslverr   = (wr_data | wr_cfg) & tx_busy_eff;

    // Pop only if the head was valid when prdata was captured in setup.
    assign fifo_pop    = access & ~pwrite & (reg_sel == DATA_OFS) & pop_armed;
    assign fifo_push   = rx_done & (~fifo_full | fifo_pop);
    assign overrun_set = rx_done & fifo_full & ~fifo_pop;
    assign perr_set    = fifo_push & parity_error;

    apb_uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (9)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({parity_error, rx_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_vec              = '0;
        status_vec[ST_TX_BUSY]  = tx_busy_eff;
        status_vec[ST_RX_AVAIL] = ~fifo_empty;
        status_vec[ST_RX_FULL]  = fifo_full;
        status_vec[ST_PERR]     = perr_sticky;
        status_vec[ST_OVERRUN]  = overrun_sticky;
        status_vec[ST_TX_DONE]  = tx_done_sticky;
    end

`ifdef APB_UART_REGIF_IRQ_EN
    logic [2:0] irq_en_q;
    logic       wr_irqen;

    assign wr_irqen = access & pwrite & (reg_sel == IRQEN_OFS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_irqen) irq_en_q <= pwdata[2:0];
            irq <= |(irq_en_q & {tx_done_sticky, overrun_sticky, ~fifo_empty});
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            DATA_OFS:   rdata = fifo_empty ? 32'd0 : {23'd0, fifo_dout};
            CFG_OFS:    rdata = {27'd0, cfg_q};
            STATUS_OFS: rdata = {26'd0, status_vec};
`ifdef APB_UART_REGIF_IRQ_EN
            IRQEN_OFS:  rdata = {29'd0, irq_en_q};
`endif
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata    <= '0;
            pop_armed <= 1'b0;
        end else if (setup) begin
            prdata    <= pwrite ? 32'd0 : rdata;
            pop_armed <= ~pwrite & (reg_sel == DATA_OFS) & ~fifo_empty;
        end else if (!access) begin
            prdata    <= '0;
            pop_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_start <= 1'b0;
            start_q  <= 1'b0;
            cfg_q    <= cfg_t'(CFG_RESET);
        end else begin
            tx_start <= tx_accept;
            start_q  <= tx_start;
            if (tx_accept) tx_data <= pwdata[7:0];
            if (wr_cfg && !tx_busy_eff) cfg_q <= cfg_t'(pwdata[4:0]);
        end
    end

    // A set event in the same cycle as a W1C clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_sticky    <= 1'b0;
            overrun_sticky <= 1'b0;
            tx_done_sticky <= 1'b0;
        end else begin
            perr_sticky    <= perr_set    | (perr_sticky    & ~(wr_status & pwdata[ST_PERR]));
            overrun_sticky <= overrun_set | (overrun_sticky & ~(wr_status & pwdata[ST_OVERRUN]));
            tx_done_sticky <= tx_done     | (tx_done_sticky & ~(wr_status & pwdata[ST_TX_DONE]));
        end
    end

endmodule

// File: tb/tb_apb_uart_regif.sv
// tb/tb_apb_uart_regif.sv - directed and randomized checks of apb_uart_regif against a queue-based model
module tb_apb_uart_regif;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [4:0]  cfg_reg;
    logic        tx_busy, tx_done;
    logic [7:0]  rx_data;
    logic        rx_done, parity_error;
`ifdef APB_UART_REGIF_IRQ_EN
    logic        irq;
`endif

    apb_uart_regif #(.ADDR_W(4), .RX_DEPTH(DEPTH), .CFG_RESET(5'b00011)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .cfg_reg      (cfg_reg),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error)
`ifdef APB_UART_REGIF_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [8:0] mq[$];
    logic       m_perr, m_ovr, m_txd;
    logic [4:0] m_cfg;
    logic [7:0] m_txb;
    logic [2:0] m_irqen;
    int         acc_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_perr = 0; m_ovr = 0; m_txd = 0;
        m_cfg = 5'b00011; m_txb = 8'h00; m_irqen = 3'b000;
        acc_c = -100;
    endtask

    // A start is in flight for the two cycles after an accepted DATA write.
    function automatic logic busy_now();
        return tx_busy || ((cyc - acc_c) < 2);
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] sel);
        case (sel)
            2'd0: return (mq.size() > 0) ? {23'd0, mq[0]} : 32'd0;
            2'd1: return {27'd0, m_cfg};
            2'd2: return {26'd0, m_txd, m_ovr, m_perr, (mq.size() == DEPTH), (mq.size() > 0), busy_now()};
`ifdef APB_UART_REGIF_IRQ_EN
            default: return {29'd0, m_irqen};
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic void model_rx(input logic [8:0] e);
        if (mq.size() < DEPTH) begin
            mq.push_back(e);
            if (e[8]) m_perr = 1;
        end else begin
            m_ovr = 1;
        end
    endfunction

    task automatic xfer(input string tag, input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic rx_en, input logic [8:0] rx_e);
        logic [31:0] exp_rd;
        logic        exp_err, acc;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
        exp_rd = exp_read(addr[3:2]);
        @(negedge clk);
        penable = 1; rx_done = rx_en; rx_data = rx_e[7:0]; parity_error = rx_e[8];
        #1;
        exp_err = wr && (addr[3:2] <= 2'd1) && busy_now();
        acc     = wr && (addr[3:2] == 2'd0) && !exp_err;
        chk({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, exp_err});
        if (!wr) chk({tag, "_prdata"}, prdata, exp_rd);
        @(posedge clk);
        #1;
        psel = 0; penable = 0; pwrite = 0; rx_done = 0; parity_error = 0;
        if (!wr && addr[3:2] == 2'd0 && mq.size() > 0) void'(mq.pop_front());
        if (wr && addr[3:2] == 2'd2) begin
            if (wd[3]) m_perr = 0;
            if (wd[4]) m_ovr = 0;
            if (wd[5]) m_txd = 0;
        end
        if (wr && addr[3:2] == 2'd1 && !exp_err) m_cfg = wd[4:0];
`ifdef APB_UART_REGIF_IRQ_EN
        if (wr && addr[3:2] == 2'd3) m_irqen = wd[2:0];
`endif
        if (rx_en) model_rx(rx_e);
        if (acc) begin
            acc_c = cyc;
            m_txb = wd[7:0];
        end
        if (wr && addr[3:2] == 2'd0) begin
            chk({tag, "_tx_start"}, {31'd0, tx_start}, {31'd0, acc});
            chk({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, m_txb});
        end
    endtask

    task automatic rx_pulse(input logic [8:0] e);
        @(negedge clk);
        rx_done = 1; rx_data = e[7:0]; parity_error = e[8];
        @(negedge clk);
        rx_done = 0; parity_error = 0;
        model_rx(e);
    endtask

    task automatic tx_done_pulse();
        @(negedge clk);
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
        m_txd = 1;
    endtask

    initial begin
        int unsigned sel;
        logic [8:0]  e;
        logic        rxe;

        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        tx_busy = 0; tx_done = 0; rx_data = 0; rx_done = 0; parity_error = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_cfg_reg", {27'd0, cfg_reg}, 32'h03);
        chk("pready_tied", {31'd0, pready}, 32'd1);
        rst_n = 1;

        xfer("rd_cfg_rst", 0, 4'h4, 0, 0, 0);
        xfer("rd_status_rst", 0, 4'h8, 0, 0, 0);
        xfer("rd_irqen_rst", 0, 4'hC, 0, 0, 0);

        // TX: accepted write, back-to-back rejected write, busy rejection
        xfer("tx_55", 1, 4'h0, 32'h55, 0, 0);
        xfer("tx_b2b", 1, 4'h0, 32'hAA, 0, 0);
        repeat (3) @(negedge clk);
        xfer("tx_single", 1, 4'h0, 32'h3E, 0, 0);
        @(posedge clk); #1;
        chk("tx_pulse_width", {31'd0, tx_start}, 32'd0);
        repeat (3) @(negedge clk);
        tx_busy = 1;
        xfer("tx_busy", 1, 4'h0, 32'h12, 0, 0);
        xfer("cfg_busy", 1, 4'h4, 32'h1F, 0, 0);
        xfer("status_busy", 0, 4'h8, 0, 0, 0);
        tx_busy = 0;
        xfer("cfg_wr", 1, 4'h4, {$urandom} | 32'h0000_0010, 0, 0);
        chk("cfg_reg_out", {27'd0, cfg_reg}, {27'd0, m_cfg});
        xfer("cfg_rd", 0, 4'h4, 0, 0, 0);
        xfer("irqen_wr", 1, 4'hC, 32'h7, 0, 0);
        xfer("irqen_rd", 0, 4'hC, 0, 0, 0);

        // RX basic
        rx_pulse({1'b0, 8'hA5});
        xfer("rx_a5_status", 0, 4'h8, 0, 0, 0);
        xfer("rx_a5_data", 0, 4'h0, 0, 0, 0);
        xfer("rx_a5_status2", 0, 4'h8, 0, 0, 0);
        xfer("rx_empty_data", 0, 4'h0, 0, 0, 0);

        // Overrun
        for (int i = 1; i <= 5; i++) rx_pulse({1'b0, 8'(i)});
        xfer("ovr_status", 0, 4'h8, 0, 0, 0);
        for (int i = 1; i <= 4; i++) xfer("ovr_data", 0, 4'h0, 0, 0, 0);
        xfer("ovr_w1c", 1, 4'h8, 32'h10, 0, 0);
        xfer("ovr_status2", 0, 4'h8, 0, 0, 0);

        // Parity error and set-beats-clear
        rx_pulse({1'b1, 8'h3C});
        xfer("perr_data", 0, 4'h0, 0, 0, 0);
        xfer("perr_status", 0, 4'h8, 0, 0, 0);
        xfer("perr_w1c_vs_set", 1, 4'h8, 32'h08, 1, {1'b1, 8'h77});
        xfer("perr_status2", 0, 4'h8, 0, 0, 0);
        xfer("perr_w1c", 1, 4'h8, 32'h08, 0, 0);
        xfer("perr_status3", 0, 4'h8, 0, 0, 0);
        while (mq.size() > 0) xfer("drain", 0, 4'h0, 0, 0, 0);

        // Full FIFO: pop and push in the same cycle, no overrun
        for (int i = 0; i < DEPTH; i++) rx_pulse({1'b0, 8'($urandom)});
        xfer("full_poppush", 0, 4'h0, 0, 1, {1'b0, 8'hC3});
        xfer("full_status", 0, 4'h8, 0, 0, 0);
        while (mq.size() > 0) xfer("drain", 0, 4'h0, 0, 0, 0);

        // tx_done sticky
        tx_done_pulse();
        xfer("txd_status", 0, 4'h8, 0, 0, 0);
        xfer("txd_w1c", 1, 4'h8, 32'h20, 0, 0);
        xfer("txd_status2", 0, 4'h8, 0, 0, 0);

`ifdef APB_UART_REGIF_IRQ_EN
        xfer("irq_en1", 1, 4'hC, 32'h1, 0, 0);
        rx_pulse({1'b0, 8'h5A});
        @(posedge clk); #1;
        chk("irq_set", {31'd0, irq}, {31'd0, |(m_irqen & {m_txd, m_ovr, mq.size() > 0})});
        xfer("irq_pop", 0, 4'h0, 0, 0, 0);
        @(posedge clk); #1;
        chk("irq_clr", {31'd0, irq}, {31'd0, |(m_irqen & {m_txd, m_ovr, mq.size() > 0})});
`endif

        // Randomized mix against the model
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 6);
            e   = {($urandom_range(0, 3) == 0), 8'($urandom)};
            rxe = ($urandom_range(0, 2) == 0);
            case (sel)
                0, 1: rx_pulse(e);
                2: xfer("rnd_data", 0, 4'h0, 0, rxe, e);
                3: xfer("rnd_status", 0, 4'h8, 0, rxe, e);
                4: xfer("rnd_w1c", 1, 4'h8, {26'd0, 3'($urandom), 3'd0}, rxe, e);
                5: begin
                    tx_busy = 1'($urandom_range(0, 1));
                    xfer("rnd_tx", 1, 4'h0, $urandom, rxe, e);
                    tx_busy = 0;
                    if ($urandom_range(0, 1) == 1) tx_done_pulse();
                end
                default: begin
                    xfer("rnd_cfg", 1, 4'h4, $urandom, rxe, e);
                    chk("rnd_cfg_reg", {27'd0, cfg_reg}, {27'd0, m_cfg});
                end
            endcase
        end

        // Asynchronous reset while a start pulse is in flight
        repeat (3) @(negedge clk);
        rx_pulse({1'b1, 8'h66});
        xfer("prerst_tx", 1, 4'h0, 32'h99, 0, 0);
        #1 rst_n = 0;
        #1;
        chk("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("async_rst_cfg", {27'd0, cfg_reg}, 32'h03);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        xfer("postrst_status", 0, 4'h8, 0, 0, 0);
        xfer("postrst_data", 0, 4'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
